// File: rtl/vga_pkg.sv
// Shared raster timing, framebuffer geometry and palette entry layout for the
// 640x480 scanout path.
package vga_pkg;

    localparam logic [17:0] BASE = 18'h00000;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int V_TOP   = 40;

    localparam int FB_W    = 320;
    localparam int FB_H    = 200;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } pal_entry_t;

endpackage

// File: rtl/vga_palette.sv
// 256x18 colour lookup with a synchronous read port and a DAC-style
// write sequencer (index, component counter, R/G staging).
module vga_palette
    import vga_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pal_wi,
    input  logic       pal_wd,
    input  logic [7:0] pal_d,
    input  logic [7:0] rd_addr,
    input  logic       rd_clr,
    output pal_entry_t rd_q
);

    pal_entry_t mem [256];

    logic [7:0] idx;
    logic [1:0] cnt;
    logic [5:0] hold_r;
    logic [5:0] hold_g;
    logic       commit;

    // Only the blue write touches the RAM, so a half-loaded entry never shows.
    assign commit = pal_wd && !pal_wi && (cnt == 2'd2);

    always_ff @(posedge clock) begin
        if (reset_n && commit)
            mem[idx] <= {hold_r, hold_g, pal_d[5:0]};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx    <= 8'd0;
            cnt    <= 2'd0;
            hold_r <= 6'd0;
            hold_g <= 6'd0;
            rd_q   <= '0;
        end else begin
            rd_q <= rd_clr ? pal_entry_t'('0) : mem[rd_addr];
            if (pal_wi) begin
                idx <= pal_d;
                cnt <= 2'd0;
            end else if (pal_wd) begin
                case (cnt)
                    2'd0: begin
                        hold_r <= pal_d[5:0];
                        cnt    <= 2'd1;
                    end
                    2'd1: begin
                        hold_g <= pal_d[5:0];
                        cnt    <= 2'd2;
                    end
                    default: begin
                        cnt <= 2'd0;
                        idx <= idx + 8'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_scan13.sv
// Pixel-doubled 320x200 framebuffer scanout into a 640x480@60 raster,
// three clocks from counter state to pins.
module vga_scan13 #(
    parameter logic [17:0] BASE   = vga_pkg::BASE,
    parameter int          H_VIS  = vga_pkg::H_VIS,
    parameter int          H_FP   = vga_pkg::H_FP,
    parameter int          H_SYNC = vga_pkg::H_SYNC,
    parameter int          H_BP   = vga_pkg::H_BP,
    parameter int          V_VIS  = vga_pkg::V_VIS,
    parameter int          V_FP   = vga_pkg::V_FP,
    parameter int          V_SYNC = vga_pkg::V_SYNC,
    parameter int          V_BP   = vga_pkg::V_BP,
    parameter int          V_TOP  = vga_pkg::V_TOP,
    parameter int          PIC_H  = vga_pkg::FB_H
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [17:0] a,
    input  logic [7:0]  i,
    input  logic        pal_wi,
    input  logic        pal_wd,
    input  logic [7:0]  pal_d,
    output logic [5:0]  r,
    output logic [5:0]  g,
    output logic [5:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        vretrace
);
    import vga_pkg::*;

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_VIS);
    localparam logic [9:0] H_SS   = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_RET  = 10'(V_VIS);
    localparam logic [9:0] V_SS   = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_PIC0 = 10'(V_TOP);
    localparam logic [9:0] V_PIC1 = 10'(V_TOP + 2 * PIC_H);

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] sy;
    logic       act0, hs0, vs0;
    logic       act1, hs1, vs1;
    logic       act2, hs2, vs2;
    pal_entry_t pal_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hc <= 10'd0;
            vc <= 10'd0;
        end else if (hc == H_LAST) begin
            hc <= 10'd0;
            vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign act0     = (hc < H_ACT) && (vc >= V_PIC0) && (vc < V_PIC1);
    assign hs0      = !((hc >= H_SS) && (hc <= H_SE));
    assign vs0      = !((vc >= V_SS) && (vc <= V_SE));
    assign sy       = (vc - V_PIC0) >> 1;
    assign vretrace = (vc >= V_RET);

    // Framebuffer stride is 320 = 256 + 64, so the row offset is two shifts.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a    <= BASE;
            act1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            act2 <= 1'b0;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
            hs   <= 1'b1;
            vs   <= 1'b1;
        end else begin
            if (act0)
                a <= BASE + (18'(sy) << 8) + (18'(sy) << 6) + 18'(hc >> 1);
            act1 <= act0;
            hs1  <= hs0;
            vs1  <= vs0;
            act2 <= act1;
            hs2  <= hs1;
            vs2  <= vs1;
            hs   <= hs2;
            vs   <= vs2;
        end
    end

    // The palette output register doubles as the r/g/b pin stage; blank clears it.
    vga_palette u_pal (
        .clock   (clock),
        .reset_n (reset_n),
        .pal_wi  (pal_wi),
        .pal_wd  (pal_wd),
        .pal_d   (pal_d),
        .rd_addr (i),
        .rd_clr  (!act2),
        .rd_q    (pal_q)
    );

    assign r = pal_q.r;
    assign g = pal_q.g;
    assign b = pal_q.b;

endmodule

// File: tb/tb_vga_scan13.sv
// Bench for vga_scan13: a full-size raster instance and a short-frame instance
// share one palette port and one framebuffer image.
module tb_vga_scan13;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        pal_wi  = 1'b0;
    logic        pal_wd  = 1'b0;
    logic [7:0]  pal_d   = 8'd0;

    logic [17:0] a_d, a_s;
    logic [7:0]  i_d = 8'd0, i_s = 8'd0;
    logic [5:0]  r_d, g_d, b_d, r_s, g_s, b_s;
    logic        hs_d, vs_d, vr_d, hs_s, vs_s, vr_s;

    logic [7:0]  mem [0:63999];
    logic [17:0] pal_exp [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #20 clock = ~clock;

    vga_scan13 dut_d (
        .clock (clock), .reset_n (reset_n), .a (a_d), .i (i_d),
        .pal_wi (pal_wi), .pal_wd (pal_wd), .pal_d (pal_d),
        .r (r_d), .g (g_d), .b (b_d), .hs (hs_d), .vs (vs_d), .vretrace (vr_d)
    );

    vga_scan13 #(
        .BASE (18'h20000), .V_VIS (24), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .V_TOP (4), .PIC_H (8)
    ) dut_s (
        .clock (clock), .reset_n (reset_n), .a (a_s), .i (i_s),
        .pal_wi (pal_wi), .pal_wd (pal_wd), .pal_d (pal_d),
        .r (r_s), .g (g_s), .b (b_s), .hs (hs_s), .vs (vs_s), .vretrace (vr_s)
    );

    function automatic logic [7:0] mem_at(input logic [17:0] off);
        return (off < 18'd64000) ? mem[off] : 8'h00;
    endfunction

    // Video RAM: data valid one clock after the address.
    always @(posedge clock) begin
        i_d <= mem_at(a_d);
        i_s <= mem_at(a_s - 18'h20000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pins at cycle t reflect raster state t-3; vretrace reflects state t.
    function automatic logic [20:0] expect_pins(input int t, input int vt, input int vvis,
                                                input int vfp, input int vsync,
                                                input int vtop, input int pich);
        int s, hc, vc, vct, off;
        logic [17:0] px;
        logic h, v, vr;
        vct = (t / 800) % vt;
        vr  = (vct >= vvis);
        px  = 18'd0;
        h   = 1'b1;
        v   = 1'b1;
        s   = t - 3;
        if (s >= 0) begin
            hc = s % 800;
            vc = (s / 800) % vt;
            h  = !(hc >= 656 && hc <= 751);
            v  = !(vc >= vvis + vfp && vc < vvis + vfp + vsync);
            if (hc < 640 && vc >= vtop && vc < vtop + 2 * pich) begin
                off = ((vc - vtop) / 2) * 320 + hc / 2;
                px  = pal_exp[mem[off]];
            end
        end
        return {px, h, v, vr};
    endfunction

    task automatic pal_op(input logic wi, input logic wd, input logic [7:0] d);
        pal_wi = wi;
        pal_wd = wd;
        pal_d  = d;
        @(negedge clock);
        pal_wi = 1'b0;
        pal_wd = 1'b0;
    endtask

    // Palette loading, all done while both rasters are in the top border.
    initial begin
        @(posedge reset_n);
        @(negedge clock);
        pal_op(1, 0, 8'd0);
        pal_op(0, 1, 8'd1); pal_op(0, 1, 8'd1); pal_op(0, 1, 8'd1);
        pal_op(1, 0, 8'd5);
        pal_op(0, 1, 8'd63); pal_op(0, 1, 8'd0);  pal_op(0, 1, 8'd0);
        pal_op(0, 1, 8'd0);  pal_op(0, 1, 8'd63); pal_op(0, 1, 8'd0);
        check("pal_idx_after_5_6", 32'(dut_d.u_pal.idx), 32'd7);
        pal_op(0, 1, 8'd1); pal_op(0, 1, 8'd2); pal_op(0, 1, 8'd3);
        pal_op(1, 0, 8'd10);
        pal_op(0, 1, 8'd20); pal_op(0, 1, 8'd21); pal_op(0, 1, 8'd22);
        check("pal_idx_after_10", 32'(dut_d.u_pal.idx), 32'd11);
        pal_op(1, 0, 8'd255);
        pal_op(0, 1, 8'd40); pal_op(0, 1, 8'd41); pal_op(0, 1, 8'd42);
        check("pal_idx_wrap", 32'(dut_d.u_pal.idx), 32'd0);
        pal_op(1, 0, 8'd10);
        pal_op(0, 1, 8'd1); pal_op(0, 1, 8'd2);
        check("pal_cnt_staged", 32'(dut_d.u_pal.cnt), 32'd2);
        pal_op(1, 1, 8'd9);
        check("pal_wi_wins_idx", 32'(dut_d.u_pal.idx), 32'd9);
        check("pal_wi_wins_cnt", 32'(dut_d.u_pal.cnt), 32'd0);
        pal_op(0, 1, 8'd30); pal_op(0, 1, 8'd31); pal_op(0, 1, 8'd32);
        check("pal_idx_after_9", 32'(dut_d.u_pal.idx), 32'd10);
    end

    initial begin
        int  t;
        bit  ph2;
        for (int k = 0; k < 64000; k++) mem[k] = 8'd0;
        mem[0]     = 8'd5;
        mem[1]     = 8'd9;
        mem[320]   = 8'd6;
        mem[321]   = 8'd10;
        mem[639]   = 8'd255;
        mem[2559]  = 8'd7;
        mem[63999] = 8'd7;
        for (int k = 0; k < 256; k++) pal_exp[k] = 18'd0;
        pal_exp[0]   = {6'd1,  6'd1,  6'd1};
        pal_exp[5]   = {6'd63, 6'd0,  6'd0};
        pal_exp[6]   = {6'd0,  6'd63, 6'd0};
        pal_exp[7]   = {6'd1,  6'd2,  6'd3};
        pal_exp[9]   = {6'd30, 6'd31, 6'd32};
        pal_exp[10]  = {6'd20, 6'd21, 6'd22};
        pal_exp[255] = {6'd40, 6'd41, 6'd42};

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check("rst_a_d", 32'(a_d), 32'd0);
        check("rst_a_s", 32'(a_s), 32'h20000);
        t   = 0;
        ph2 = 1'b0;
        while (!(ph2 && t > 4000) && n_bad <= 40) begin
            check($sformatf("pins_d ph%0d t=%0d", ph2, t),
                  32'({r_d, g_d, b_d, hs_d, vs_d, vr_d}), 32'(expect_pins(t, 525, 480, 10, 2, 40, 200)));
            check($sformatf("pins_s ph%0d t=%0d", ph2, t),
                  32'({r_s, g_s, b_s, hs_s, vs_s, vr_s}), 32'(expect_pins(t, 30, 24, 2, 2, 4, 8)));
            if (!ph2) begin
                if (t == 32002) check("l40_latency", 32'({r_d, g_d, b_d}), 32'd0);
                if (t == 32003) check("l40_c0", 32'({r_d, g_d, b_d}), 32'({6'd63, 6'd0, 6'd0}));
                if (t == 32004) check("l40_c1", 32'({r_d, g_d, b_d}), 32'({6'd63, 6'd0, 6'd0}));
                if (t == 32004) check("a_l40_c3", 32'(a_d), 32'd1);
                if (t == 33603) check("l42_c0", 32'({r_d, g_d, b_d}), 32'({6'd0, 6'd63, 6'd0}));
                if (t == 34403) check("l43_c0", 32'({r_d, g_d, b_d}), 32'({6'd0, 6'd63, 6'd0}));
                if (t == 15840) check("a_last_px", 32'(a_s), 32'h209FF);
                if (t == 15842) check("last_px", 32'({r_s, g_s, b_s}), 32'({6'd1, 6'd2, 6'd3}));
                if (t == 15843) check("blank_hc640", 32'({r_s, g_s, b_s}), 32'd0);
                if (t == 19199) check("vretrace_l23", 32'(vr_s), 32'd0);
                if (t == 19200) check("vretrace_l24", 32'(vr_s), 32'd1);
                if (t == 659)   check("hs_fall", 32'(hs_d), 32'd0);
                if (t == 755)   check("hs_rise", 32'(hs_d), 32'd1);
            end else begin
                if (t == 0) check("rst_mid_hc", 32'(dut_d.hc), 32'd0);
                if (t == 0) check("rst_mid_vc", 32'(dut_d.vc), 32'd0);
                if (t == 0) check("rst_mid_pins", 32'({r_d, g_d, b_d, hs_d, vs_d}), 32'h3);
                if (t == 3203) check("resume_s", 32'({r_s, g_s, b_s}), 32'({6'd63, 6'd0, 6'd0}));
            end
            // dut_d sits at hc=300 on line 62, inside the picture.
            if (!ph2 && t == 49900) begin
                check("pre_rst_px", 32'({r_d, g_d, b_d}), 32'({6'd1, 6'd1, 6'd1}));
                reset_n = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
                ph2 = 1'b1;
                t   = 0;
            end else begin
                @(negedge clock);
                t++;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
